// File: rtl/assoc_search_ctrl_pkg.sv
// Shared constants, FSM state type and priority helper for the
// sequential associative-search controller.
package assoc_search_ctrl_pkg;

  localparam int WORDS = 8;
  localparam int WIDTH = 4;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  // Lowest set index of a match vector; 0 when the vector is empty.
  function automatic logic [IDX_W-1:0] lowest_index(input logic [WORDS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int unsigned i = WORDS; i > 0; i--) begin
      if (v[i-1]) r = IDX_W'(i - 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/assoc_search_ctrl_fulladd.sv
// 4-bit full adder; the controller's only comparison resource.
module fulladd (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};

endmodule

// File: rtl/assoc_search_ctrl.sv
// Associative search over an 8x4 word store, one word per cycle through a
// shared adder (word + ~key + 1 == 0 means word == key).
module assoc_search_ctrl
  import assoc_search_ctrl_pkg::*;
#(
  parameter int WORDS = 8,
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              srch_start,
  input  logic [WIDTH-1:0]  srch_key,
  output logic              busy,
  output logic              done,
  output logic [WORDS-1:0]  match_vec,
  output logic              hit,
  output logic [IDX_W-1:0]  hit_addr,
  output logic              wr_err
);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   key;
  logic [WIDTH-1:0]   mem [WORDS];
  logic [WIDTH-1:0]   word_cur;
  logic [WIDTH-1:0]   key_n;
  logic [WIDTH-1:0]   fa_sum;
  logic               unused_cout;
  logic               is_match;
  logic [WORDS-1:0]   scan_vec;
  logic               last_idx;

  assign word_cur = mem[idx];
  assign key_n    = ~key;
  assign is_match = (fa_sum == '0);
  assign last_idx = (idx == IDX_W'(WORDS - 1));

  fulladd u_fulladd (
    .a     (word_cur),
    .b     (key_n),
    .c_in  (1'b1),
    .sum   (fa_sum),
    .c_out (unused_cout)
  );

  // Match vector as it will look after the current scan edge, so the final
  // hit/hit_addr can be registered on the same edge as the last match bit.
  always_comb begin
    scan_vec      = match_vec;
    scan_vec[idx] = is_match;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (srch_start) state_nxt = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (last_idx) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      key       <= '0;
      match_vec <= '0;
      hit       <= 1'b0;
      hit_addr  <= '0;
      wr_err    <= 1'b0;
      for (int unsigned i = 0; i < WORDS; i++) mem[i] <= '0;
    end else begin
      state  <= state_nxt;
      wr_err <= wr_en && (state != IDLE);
      if (wr_en && state == IDLE) mem[wr_addr] <= wr_data;
      case (state)
        IDLE: begin
          if (srch_start) begin
            key       <= srch_key;
            idx       <= '0;
            match_vec <= '0;
            hit       <= 1'b0;
            hit_addr  <= '0;
          end
        end
        SCAN: begin
          match_vec[idx] <= is_match;
          if (last_idx) begin
            hit      <= |scan_vec;
            hit_addr <= lowest_index(scan_vec);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_assoc_search_ctrl.sv
// Self-checking bench: directed cases with literal expectations plus random
// traffic, all outputs compared each cycle against a behavioural model.
module tb_assoc_search_ctrl;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       srch_start;
  logic [3:0] srch_key;
  logic       busy;
  logic       done;
  logic [7:0] match_vec;
  logic       hit;
  logic [2:0] hit_addr;
  logic       wr_err;

  int n_checks = 0;
  int n_pass   = 0;

  assoc_search_ctrl #(.WORDS(8), .WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .srch_start (srch_start),
    .srch_key   (srch_key),
    .busy       (busy),
    .done       (done),
    .match_vec  (match_vec),
    .hit        (hit),
    .hit_addr   (hit_addr),
    .wr_err     (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a search is a snapshot of which words equal the key,
  // revealed one bit per cycle over eight cycles, then reported for a cycle.
  int         m_cyc;          // 0 idle, 1..8 scanning, 9 done
  logic [3:0] m_mem [8];
  logic [7:0] m_full;
  logic [7:0] m_vec;
  logic       m_hit;
  logic [2:0] m_addr;
  logic       m_wr_err;
  bit         m_valid = 0;

  task automatic model_step();
    if (rst) begin
      m_cyc = 0;
      for (int i = 0; i < 8; i++) m_mem[i] = 4'h0;
      m_vec = 8'h00; m_hit = 1'b0; m_addr = 3'd0; m_wr_err = 1'b0; m_full = 8'h00;
      m_valid = 1;
    end else begin
      m_wr_err = wr_en && (m_cyc != 0);
      if (m_cyc == 0) begin
        if (wr_en) m_mem[wr_addr] = wr_data;
        if (srch_start) begin
          m_full = 8'h00;
          for (int i = 0; i < 8; i++) if (m_mem[i] == srch_key) m_full[i] = 1'b1;
          m_cyc = 1; m_vec = 8'h00; m_hit = 1'b0; m_addr = 3'd0;
        end
      end else if (m_cyc == 9) begin
        m_cyc = 0;
      end else begin
        m_cyc++;
        if (m_cyc == 9) begin
          m_vec = m_full;
          m_hit = (m_full != 8'h00);
          m_addr = 3'd0;
          for (int i = 7; i >= 0; i--) if (m_full[i]) m_addr = 3'(i);
        end else begin
          m_vec = m_full & ((8'd1 << (m_cyc - 1)) - 8'd1);
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("busy",      32'(busy),      32'(m_cyc != 0));
      chk("done",      32'(done),      32'(m_cyc == 9));
      chk("match_vec", 32'(match_vec), 32'(m_vec));
      chk("hit",       32'(hit),       32'(m_hit));
      chk("hit_addr",  32'(hit_addr),  32'(m_addr));
      chk("wr_err",    32'(wr_err),    32'(m_wr_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic write_word(input logic [2:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic search(input logic [3:0] key, input string tag);
    int lat;
    srch_start = 1'b1; srch_key = key;
    cyc();
    srch_start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (done) begin lat = i; break; end
    end
    chk({tag, "_latency"}, 32'(lat), 32'd8);
  endtask

  int n_done;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    srch_start = 1'b0; srch_key = '0;
    cyc(); cyc();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_vec",  32'(match_vec), 32'd0);
    chk("rst_hit",  32'(hit), 32'd0);
    chk("rst_werr", 32'(wr_err), 32'd0);
    rst = 1'b0;

    // Cleared store: key 0 matches every word.
    search(4'h0, "zero");
    chk("zero_vec",  32'(match_vec), 32'hFF);
    chk("zero_hit",  32'(hit), 32'd1);
    chk("zero_addr", 32'(hit_addr), 32'd0);
    cyc();
    chk("done_one_cycle", 32'(done), 32'd0);

    for (int i = 0; i < 8; i++) write_word(3'(i), 4'(i + 1));
    search(4'h5, "single");
    chk("single_vec",  32'(match_vec), 32'h10);
    chk("single_hit",  32'(hit), 32'd1);
    chk("single_addr", 32'(hit_addr), 32'd4);
    cyc();

    for (int i = 0; i < 8; i++) write_word(3'(i), (i == 2 || i == 6) ? 4'h3 : 4'hA);
    search(4'h3, "multi");
    chk("multi_vec",  32'(match_vec), 32'h44);
    chk("multi_hit",  32'(hit), 32'd1);
    chk("multi_addr", 32'(hit_addr), 32'd2);
    cyc();
    chk("hold_vec", 32'(match_vec), 32'h44);
    search(4'hF, "none");
    chk("none_vec",  32'(match_vec), 32'h00);
    chk("none_hit",  32'(hit), 32'd0);
    chk("none_addr", 32'(hit_addr), 32'd0);
    cyc();

    // Write and start collisions during a scan of key 0xA.
    srch_start = 1'b1; srch_key = 4'hA;
    cyc();
    srch_start = 1'b0;
    cyc();
    cyc();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h3;
    cyc();
    wr_en = 1'b0;
    chk("coll_wr_err", 32'(wr_err), 32'd1);
    srch_start = 1'b1; srch_key = 4'h3;
    cyc();
    srch_start = 1'b0;
    chk("coll_wr_err_pulse", 32'(wr_err), 32'd0);
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) n_done++;
      cyc();
    end
    chk("coll_done_count", 32'(n_done), 32'd1);
    chk("coll_vec", 32'(match_vec), 32'hBB);

    // Same-edge write and start: search sees the new word 7.
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 4'h9;
    search(4'h9, "same_edge");
    wr_en = 1'b0;
    chk("same_edge_vec",  32'(match_vec), 32'h80);
    chk("same_edge_addr", 32'(hit_addr), 32'd7);
    cyc();

    // Reset abort in the fourth scan cycle.
    srch_start = 1'b1; srch_key = 4'hA;
    cyc();
    srch_start = 1'b0;
    cyc(); cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_vec",  32'(match_vec), 32'd0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) n_done++;
      cyc();
    end
    chk("abort_done_count", 32'(n_done), 32'd0);

    // Random traffic with a narrow data range so hits are frequent.
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(63) == 0);
      wr_en      = ($urandom_range(2) == 0);
      wr_addr    = 3'($urandom_range(7));
      wr_data    = 4'($urandom_range(3));
      srch_start = ($urandom_range(3) == 0);
      srch_key   = 4'($urandom_range(3));
      cyc();
    end
    rst = 1'b0; wr_en = 1'b0; srch_start = 1'b0;
    for (int i = 0; i < 12; i++) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/assoc_search_ctrl.md
ASSOC_SEARCH_CTRL -- requirements
Module: assoc_search_ctrl

Interface
REQ-001 Parameter WORDS, default 8: number of stored words; the block SHALL support only 8, with index width 3.
REQ-002 Parameter WIDTH, default 4: word and key width; the block SHALL support only 4, matching the 4-bit fulladd datapath.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 wr_en  input  1  write strobe for the word store.
REQ-006 wr_addr  input  3  write index.
REQ-007 wr_data  input  4  write data.
REQ-008 srch_start  input  1  one-cycle search request.
REQ-009 srch_key  input  4  search key, sampled only when a start is accepted.
REQ-010 busy  output  1  high while a search is in progress.
REQ-011 done  output  1  one-cycle pulse marking a completed search.
REQ-012 match_vec  output  8  per-word match flags; bit i set means word i equals the key.
REQ-013 hit  output  1  high when any bit of match_vec is set.
REQ-014 hit_addr  output  3  lowest matching index; 0 when hit is 0.
REQ-015 wr_err  output  1  one-cycle pulse when a write is dropped.

Function
REQ-016 Storage SHALL be an internal 8x4 register array, written at the clock edge when wr_en=1 and the state is IDLE.
REQ-017 FSM states SHALL be IDLE, SCAN and DONE.
REQ-018 IDLE -> SCAN on srch_start=1. On that edge the block SHALL latch srch_key, set the scan index to 0 and clear match_vec, hit and hit_addr.
REQ-019 SCAN SHALL compare one word per cycle, index 0 to 7, through a single shared fulladd instance.
  - Adder inputs: a = word[idx], b = ~key, c_in = 1.
  - Match condition: sum == 4'h0 (c_out is not used).
REQ-020 Each SCAN cycle SHALL write match_vec[idx] at its closing edge. After idx=7 the FSM SHALL go to DONE; the scan index SHALL NOT wrap within a search.
REQ-021 DONE SHALL last exactly one cycle, with done=1, and then return to IDLE.
REQ-022 busy SHALL be 1 in SCAN and DONE and 0 in IDLE.
REQ-023 Latency: a start accepted at edge N SHALL give done=1 during the cycle after edge N+8, i.e. 9 cycles after the start.
REQ-024 hit and hit_addr SHALL be valid from the cycle done=1 and SHALL hold, together with match_vec, until the next accepted start.
REQ-025 srch_start while busy=1 SHALL be ignored, with no queuing.
REQ-026 wr_en while busy=1 SHALL be dropped: storage is left unchanged and wr_err=1 for the next cycle only.
REQ-027 If wr_en and srch_start are both 1 in IDLE, the write SHALL commit on the same edge, and the search SHALL see the new data.
REQ-028 Multiple matches SHALL set every corresponding match_vec bit; hit_addr SHALL report the lowest matching index.
REQ-029 The adder SHALL be the only comparison resource; the block SHALL NOT use a parallel 8-way comparator.

Reset
REQ-030 On rst=1 at a clock edge, the block SHALL enter IDLE and clear all storage words to 4'h0.
REQ-031 The same reset SHALL clear busy, done, match_vec, hit, hit_addr and wr_err to 0.
REQ-032 rst SHALL take priority over wr_en and srch_start.
REQ-033 rst asserted mid-SCAN SHALL abort the search with no done pulse; partial match_vec contents SHALL be discarded.

Structure
REQ-034 A shared package SHALL hold:
  - constants WORDS=8, WIDTH=4 and IDX_W=3;
  - the FSM state enumeration (IDLE, SCAN, DONE).
REQ-035 The block SHALL contain exactly one sub-module: the existing fulladd (4-bit a, b, sum; 1-bit c_in, c_out), instantiated once.

Verification
REQ-036 Reset comparison case: reset, then a search with key 0x0 -> match_vec=0xFF, hit=1, hit_addr=0, done 9 cycles after the start.
REQ-037 Single match: write word i = i+1 for i=0..7, then search key 0x5 -> match_vec=0x10, hit=1, hit_addr=4.
REQ-038 No match and multiple matches:
  - words 0x3 at indices 2 and 6, all others 0xA, search key 0x3 -> match_vec=0x44, hit_addr=2;
  - search key 0xF on the same data -> match_vec=0x00, hit=0, hit_addr=0.
REQ-039 Collisions:
  - wr_en at cycle 3 of a SCAN -> wr_err pulse and storage unchanged;
  - srch_start during SCAN -> ignored and done pulses once.
REQ-040 Same-edge and reset-abort cases:
  - wr_en (addr 7, data 0x9) together with srch_start key 0x9 from IDLE -> match_vec bit 7 set;
  - rst at SCAN cycle 4 -> busy=0 and no done pulse.
